// File: rtl/shift_pkg.sv
// shift_pkg: shared encodings and defaults for the iterative shifter.
//   OP_SLL/OP_SRL/OP_SRA/OP_ROR  shift operation codes
//   ST_IDLE/ST_SHIFT/ST_DONE     sequencer states
//   SHIFT_WIDTH                  default data width
package shift_pkg;
   localparam int SHIFT_WIDTH = 8;
   typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROR = 2'b11} shift_op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: combinational single-position shift for SLL/SRL/SRA/ROR.
//   op      operation select
//   data_i  value to shift
//   data_o  value shifted by one position
module shift_stage import shift_pkg::*; #(
   parameter int WIDTH = SHIFT_WIDTH
) (
   input  shift_op_e        op,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);
   logic             fill;
   logic [WIDTH-1:0] lo, hi;
   // MSB fill for right moves: sign for SRA, wrapped LSB for ROR, zero for SRL
   assign fill = op == OP_SRA ? data_i[WIDTH-1] : op == OP_ROR ? data_i[0] : 1'b0;
   assign lo   = {data_i[WIDTH-2:0], 1'b0};
   assign hi   = {fill, data_i[WIDTH-1:1]};
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      assign data_o[i] = op == OP_SLL ? lo[i] : hi[i];
   end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: iterative shift/rotate controller with start/busy/done handshake.
//   CLK, RESET          clock, synchronous active-high reset
//   START               request strobe, sampled only when idle
//   SHIFT_OP, OPERAND,  operation, value and amount captured on accepted START
//   AMOUNT
//   BUSY                high whenever not idle
//   DONE                one-cycle pulse, RESULT valid
//   RESULT              working register, held until next accepted START
module shift_sequencer import shift_pkg::*; #(
   parameter int WIDTH = SHIFT_WIDTH,
   parameter int AMT_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [1:0]       SHIFT_OP,
   input  logic [WIDTH-1:0] OPERAND,
   input  logic [AMT_W-1:0] AMOUNT,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RESULT
);
   localparam int LW = $clog2(WIDTH);
   state_e           state_q, state_d;
   shift_op_e        op_q, op_d;
   logic [WIDTH-1:0] work_q, work_d, stage_out;
   logic [CNT_W-1:0] cnt_q, cnt_d, n_amt;
   shift_stage #(.WIDTH(WIDTH)) u_stage (.op(op_q), .data_i(work_q), .data_o(stage_out));
   // Rotates wrap modulo WIDTH; plain shifts saturate at WIDTH steps, which fully flushes the operand
   assign n_amt = SHIFT_OP == OP_ROR ? CNT_W'(AMOUNT[LW-1:0])
                : AMOUNT >= AMT_W'(WIDTH) ? CNT_W'(WIDTH) : CNT_W'(AMOUNT);
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (START) begin
            work_d  = OPERAND;
            op_d    = shift_op_e'(SHIFT_OP);
            cnt_d   = n_amt;
            state_d = n_amt == '0 ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            work_d  = stage_out;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = cnt_q == CNT_W'(1) ? ST_DONE : ST_SHIFT;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         op_q    <= OP_SLL;
         work_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
      end
   end
   assign BUSY   = state_q != ST_IDLE;
   assign DONE   = state_q == ST_DONE;
   assign RESULT = work_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench with directed and random shift requests.
module tb_shift_sequencer;
   logic       CLK = 0, RESET = 1, START = 0;
   logic [1:0] SHIFT_OP = 0;
   logic [7:0] OPERAND = 0, AMOUNT = 0;
   logic       BUSY, DONE;
   logic [7:0] RESULT;
   int         cyc = 0, compared = 0, mismatched = 0;
   typedef struct {logic [7:0] res; int due;} exp_t;
   exp_t       sb[$];
   logic [7:0] last_res;

   shift_sequencer dut (.CLK(CLK), .RESET(RESET), .START(START), .SHIFT_OP(SHIFT_OP),
                        .OPERAND(OPERAND), .AMOUNT(AMOUNT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [7:0] model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] amt);
      logic [15:0] dbl;
      dbl = {a, a} >> (amt % 8);
      case (op)
         2'd0: return amt >= 8 ? 8'h00 : 8'(a << amt);
         2'd1: return amt >= 8 ? 8'h00 : a >> amt;
         2'd2: return amt >= 8 ? {8{a[7]}} : 8'($signed(a) >>> amt);
         default: return dbl[7:0];
      endcase
   endfunction

   function automatic int steps(input logic [1:0] op, input logic [7:0] amt);
      return op == 2'd3 ? int'(amt) % 8 : (amt < 8 ? int'(amt) : 8);
   endfunction

   task automatic check(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every DONE pulse must match the oldest outstanding request
   always @(negedge CLK) begin
      if (!RESET && DONE) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got DONE=1 expected no pulse (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("done_result", RESULT, e.res);
            check("done_cycle", cyc, e.due);
            last_res = e.res;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] amt, input bit push);
      int acc;
      @(negedge CLK);
      SHIFT_OP = op; OPERAND = a; AMOUNT = amt; START = 1;
      @(posedge CLK); #1;
      START = 0;
      acc = cyc;
      check("busy_after_accept", BUSY, 1);
      if (push) sb.push_back('{model(op, a, amt), acc + steps(op, amt)});
      SHIFT_OP = 2'($urandom); OPERAND = 8'($urandom); AMOUNT = 8'($urandom);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (BUSY && t < 40) begin
         @(posedge CLK); #1;
         t++;
      end
      if (BUSY) check("idle_timeout", 1, 0);
   endtask

   task automatic run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] amt);
      issue(op, a, amt, 1);
      wait_idle();
      repeat (2) @(posedge CLK);
      #1;
      check("result_held", RESULT, model(op, a, amt));
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      check("reset_busy", BUSY, 0);
      check("reset_done", DONE, 0);
      check("reset_result", RESULT, 0);
      RESET = 0;
      run(2'd0, 8'h81, 8'd1);
      run(2'd2, 8'h90, 8'd3);
      run(2'd2, 8'h90, 8'd20);
      run(2'd3, 8'h01, 8'd9);
      run(2'd3, 8'hA5, 8'd8);
      run(2'd1, 8'h7E, 8'd0);
      // SRL saturating, with a stray START mid-operation that must be ignored
      issue(2'd1, 8'hFF, 8'd200, 1);
      repeat (3) @(negedge CLK);
      START = 1; OPERAND = 8'h0F; SHIFT_OP = 2'd0; AMOUNT = 8'd1;
      @(negedge CLK);
      START = 0;
      wait_idle();
      repeat (3) @(posedge CLK);
      #1;
      check("ignored_start_result", RESULT, 8'h00);
      // Reset sampled on the edge of the third shift discards the operation
      issue(2'd0, 8'h01, 8'd6, 0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET = 1;
      @(posedge CLK); #1;
      RESET = 0;
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      check("abort_result", RESULT, 0);
      repeat (12) @(posedge CLK);
      #1;
      check("abort_stays_idle", BUSY, 0);
      // START held high: a new op is accepted every N+2 edges
      begin
         int acc;
         @(negedge CLK);
         SHIFT_OP = 2'd0; OPERAND = 8'h01; AMOUNT = 8'd2; START = 1;
         @(posedge CLK); #1;
         acc = cyc;
         for (int i = 0; i < 3; i++) sb.push_back('{8'h04, acc + 4 * i + 2});
         while (cyc < acc + 8) @(posedge CLK);
         #1;
         START = 0;
         check("b2b_third_accept", BUSY, 1);
         wait_idle();
      end
      for (int i = 0; i < 40; i++) begin
         logic [7:0] amt;
         amt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
         run(2'($urandom), 8'($urandom), amt);
      end
      repeat (4) @(posedge CLK);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
